tmul_uni_par: RTL and testbench
===============================

# tmul_uni_par

Parametrised multi-channel temporal-coded unipolar stochastic multiplier. Operand A is held as a down-counter and defines a window of exactly A active cycles. Each of CH B operands is compared against a shared bit-reversed (Sobol dimension-1) sequence during that window to produce CH product bitstreams. Per-channel one-counters give the binary product, so the block can feed either bitstream consumers or binary datapaths in the SC unit library.

## Interface
- WIDTH, 8: operand width; the sequence and all counters are WIDTH bits.
- CH, 4: number of B channels sharing one A window and one sequence generator.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- iA  in  WIDTH  multiplier A, unsigned; value = window length in cycles.
- iB  in  CH*WIDTH  B operands; channel i occupies bits [i*WIDTH +: WIDTH].
- start  in  1  load operands and begin a run; honoured in IDLE and DONE only.
- abort  in  1  terminate the current run; return to IDLE with no done pulse.
- oC  out  CH  product bitstreams; bit i is 1 only in RUN.
- oCnt  out  CH*WIDTH  per-channel one-count of oC, channel i at [i*WIDTH +: WIDTH].
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: oC=0, oCnt=0, busy=0, done=0. The A counter, sequence index and all B buffers are cleared to 0.
- IDLE/DONE with start=1:
  - Capture iA into the A counter and iB into the B buffers.
  - Clear the index and all oCnt.
  - Next state is RUN if iA!=0. Otherwise next state is DONE, so a zero-length run still pulses done.
- IDLE/DONE with start=0:
  - DONE always goes to IDLE.
  - IDLE holds.
  - oCnt holds its last value until the next accepted start.
- RUN:
  - seq = bit-reverse(index), i.e. seq[j] = index[WIDTH-1-j].
  - oC[i] = (B_i > seq), unsigned compare. oC is combinational from registered state and gated by RUN.
  - Each cycle:
    - oCnt[i] += oC[i].
    - index += 1.
    - A counter -= 1.
    - When the A counter is 1, the next state is DONE.
- start during RUN is ignored. No reload and no restart.
- abort has priority over start and RUN progression.
  - In RUN, abort forces IDLE on the next edge. oCnt keeps its partial value and done is not pulsed.
  - In IDLE/DONE, abort cancels a simultaneous start: no capture, next state IDLE.
- rst has priority over everything. Reset mid-run forces the reset values above.
- Arithmetic and wrap rules:
  - Run length A is at most 2^WIDTH-1, so index never wraps within a run.
  - oCnt[i] is at most A, so it cannot overflow WIDTH bits.
  - oCnt[i] = |{k in 0..A-1 : bitrev(k) < B_i}|, which approximates A*B_i/2^WIDTH.

## Timing
- Start sampled at edge t gives RUN during cycles t+1 .. t+A. oC is valid in those A cycles and busy is high in them.
- done is high in cycle t+A+1, and oCnt is final at that point. IDLE follows at t+A+2 unless start is asserted in DONE, in which case RUN follows back-to-back.
- For A=0, done is high in cycle t+1 with oCnt=0.
- Latency from start to done is A+1 cycles. Throughput is one run per A+1 cycles.
- abort sampled at edge u during RUN gives IDLE in cycle u+1. oC=0 and busy=0 from u+1.

## Test plan
- WIDTH=8, reset with rst held 2 cycles: all outputs 0 and state IDLE. Assert start with rst high: ignored.
- A=255, B={128,0,255,64}, start: busy for 255 cycles. done at start+256 with oCnt={128,0,255,64}. oC[0] pattern 1,0,1,0,… from the first RUN cycle.
- A=128, B={64,128,32,1}: oCnt={32,64,16,1} at done. Total RUN cycles = 128.
- A=0, B=any: no RUN cycle, oC never 1. done at start+1 with oCnt=0.
- Hold start high continuously with A=3, B0=255: runs repeat every 4 cycles, with done in every 4th cycle. start in RUN has no effect and oCnt[0]=3 at each done.
- A=200, abort in the 10th RUN cycle: IDLE next cycle, no done, oCnt holds the 10-cycle partial count. Assert rst in RUN of a fresh run: all outputs 0 next cycle.

Source files
------------

// File: rtl/tmul_uni_par_if.sv
// Operand/result bundle for the temporal-coded stochastic multiplier.
// master drives operands and run control; slave is the multiplier.
interface tmul_uni_par_if #(
  parameter int WIDTH = 8,
  parameter int CH    = 4
);
  logic [WIDTH-1:0]    iA;
  logic [CH*WIDTH-1:0] iB;
  logic                start;
  logic                abort;
  logic [CH-1:0]       oC;
  logic [CH*WIDTH-1:0] oCnt;
  logic                busy;
  logic                done;

  modport master (
    output iA, iB, start, abort,
    input  oC, oCnt, busy, done
  );

  modport slave (
    input  iA, iB, start, abort,
    output oC, oCnt, busy, done
  );
endinterface

// File: rtl/tmul_uni_par.sv
// Multi-channel unipolar SC multiplier: A sets a window of A cycles, each B is compared to a shared bit-reversed index.
// Latency start->done is A+1 cycles; no backpressure, start is only honoured in IDLE/DONE and abort wins over everything but rst.
module tmul_uni_par #(
  parameter int WIDTH = 8,
  parameter int CH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  tmul_uni_par_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t                     state_q, state_d;
  logic [WIDTH-1:0]           a_q;
  logic [WIDTH-1:0]           idx_q;
  logic [WIDTH-1:0]           seq;
  logic [CH-1:0][WIDTH-1:0]   b_q;
  logic [CH-1:0][WIDTH-1:0]   cnt_q;
  logic [CH-1:0]              c_bits;
  logic                       accept;

  // Sobol dimension-1 sequence is simply the index with its bits mirrored.
  always_comb begin
    seq = '0;
    for (int j = 0; j < WIDTH; j++) begin
      seq[j] = idx_q[WIDTH-1-j];
    end
  end

  always_comb begin
    c_bits = '0;
    for (int i = 0; i < CH; i++) begin
      c_bits[i] = (state_q == RUN) && (b_q[i] > seq);
    end
  end

  assign accept = (state_q != RUN) && bus.start && !bus.abort;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (bus.abort)       state_d = IDLE;
        else if (a_q == ONE) state_d = DONE;
        else                 state_d = RUN;
      end
      default: begin
        if (accept) state_d = (bus.iA != '0) ? RUN : DONE;
        else        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      idx_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= bus.iA;
        b_q   <= bus.iB;
        idx_q <= '0;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        // The aborting cycle still counts its emitted bits so oCnt matches oC.
        a_q   <= a_q - ONE;
        idx_q <= idx_q + ONE;
        for (int i = 0; i < CH; i++) begin
          cnt_q[i] <= cnt_q[i] + {{(WIDTH-1){1'b0}}, c_bits[i]};
        end
      end
    end
  end

  assign bus.oC   = c_bits;
  assign bus.oCnt = cnt_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_tmul_uni_par.sv
// Randomized self-checking bench for tmul_uni_par against a counting reference model.
module tb_tmul_uni_par;
  localparam int W  = 8;
  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tmul_uni_par_if #(.WIDTH(W), .CH(CH)) bus ();
  tmul_uni_par #(.WIDTH(W), .CH(CH)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic int bitrev(input int k);
    int r = 0;
    for (int j = 0; j < W; j++) begin
      if (((k >> j) & 1) == 1) r = r | (1 << (W - 1 - j));
    end
    return r;
  endfunction

  function automatic logic [CH-1:0] ref_oc(input int k, input logic [CH*W-1:0] bv);
    logic [CH-1:0] r = '0;
    for (int i = 0; i < CH; i++) r[i] = (bitrev(k) < int'(bv[i*W +: W]));
    return r;
  endfunction

  function automatic logic [CH*W-1:0] ref_cnt(input int a, input logic [CH*W-1:0] bv);
    logic [CH*W-1:0] r = '0;
    for (int i = 0; i < CH; i++) begin
      int c = 0;
      for (int k = 0; k < a; k++) if (bitrev(k) < int'(bv[i*W +: W])) c++;
      r[i*W +: W] = c[W-1:0];
    end
    return r;
  endfunction

  function automatic logic [CH*W-1:0] pack4(input int b0, input int b1, input int b2, input int b3);
    logic [CH*W-1:0] r;
    r[0*W +: W] = b0[W-1:0];
    r[1*W +: W] = b1[W-1:0];
    r[2*W +: W] = b2[W-1:0];
    r[3*W +: W] = b3[W-1:0];
    return r;
  endfunction

  // Drives one start pulse; returns at the falling edge of the first cycle after the start edge.
  task automatic launch(input int a, input logic [CH*W-1:0] bv);
    @(negedge clk);
    bus.iA    = a[W-1:0];
    bus.iB    = bv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.abort = 1'b0;
    bus.start = 1'b1;
    bus.iA    = 8'd5;
    bus.iB    = pack4(255, 255, 255, 255);
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.oC, bus.oCnt} !== '0)
      $display("FAIL reset_outputs busy=%b done=%b oC=%h oCnt=%h expected all 0",
               bus.busy, bus.done, bus.oC, bus.oCnt);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00)
      $display("FAIL reset_idle busy=%b done=%b expected 0 0", bus.busy, bus.done);
    if ({bus.busy, bus.done} !== 2'b00 || {bus.busy, bus.done, bus.oC, bus.oCnt} !== '0) errors++;
  endtask

  task automatic test_window(input int a, input logic [CH*W-1:0] bv, input string name);
    logic [CH*W-1:0] exp_cnt = ref_cnt(a, bv);
    launch(a, bv);
    for (int k = 0; k < a; k++) begin
      checks += 2;
      if ({bus.busy, bus.done} !== 2'b10) begin
        errors++;
        $display("FAIL %s_busy cycle %0d busy=%b done=%b expected 1 0", name, k, bus.busy, bus.done);
      end
      if (bus.oC !== ref_oc(k, bv)) begin
        errors++;
        $display("FAIL %s_oc cycle %0d got %b expected %b", name, k, bus.oC, ref_oc(k, bv));
      end
      @(negedge clk);
    end
    checks += 2;
    if ({bus.busy, bus.done} !== 2'b01) begin
      errors++;
      $display("FAIL %s_done busy=%b done=%b expected 0 1", name, bus.busy, bus.done);
    end
    if (bus.oCnt !== exp_cnt) begin
      errors++;
      $display("FAIL %s_cnt got %h expected %h", name, bus.oCnt, exp_cnt);
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.oC} !== '0 || bus.oCnt !== exp_cnt) begin
      errors++;
      $display("FAIL %s_after busy=%b done=%b oC=%b oCnt=%h expected idle, oCnt %h",
               name, bus.busy, bus.done, bus.oC, bus.oCnt, exp_cnt);
    end
  endtask

  task automatic test_zero();
    launch(0, pack4($urandom_range(1, 255), 255, 17, 200));
    checks++;
    if ({bus.busy, bus.done, bus.oC, bus.oCnt} !== {2'b01, {CH{1'b0}}, {(CH*W){1'b0}}}) begin
      errors++;
      $display("FAIL zero_done busy=%b done=%b oC=%b oCnt=%h expected 0 1 0 0",
               bus.busy, bus.done, bus.oC, bus.oCnt);
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.oC} !== '0) begin
      errors++;
      $display("FAIL zero_after busy=%b done=%b oC=%b expected 0", bus.busy, bus.done, bus.oC);
    end
  endtask

  task automatic test_back_to_back();
    logic [CH*W-1:0] bv = pack4(255, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    @(negedge clk);
    bus.iA    = 8'd3;
    bus.iB    = bv;
    bus.start = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({bus.busy, bus.done} !== 2'b10 || bus.oC !== ref_oc(k, bv)) begin
          errors++;
          $display("FAIL b2b_run run %0d cycle %0d busy=%b done=%b oC=%b expected 1 0 %b",
                   r, k, bus.busy, bus.done, bus.oC, ref_oc(k, bv));
        end
        @(negedge clk);
      end
      checks += 2;
      if (bus.done !== 1'b1) begin
        errors++;
        $display("FAIL b2b_done run %0d done=%b expected 1", r, bus.done);
      end
      if (bus.oCnt !== ref_cnt(3, bv) || bus.oCnt[W-1:0] !== 8'd3) begin
        errors++;
        $display("FAIL b2b_cnt run %0d got %h expected %h", r, bus.oCnt, ref_cnt(3, bv));
      end
      if (r == 2) bus.start = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_abort();
    logic [CH*W-1:0] bv = pack4($urandom_range(0, 255), $urandom_range(0, 255), 255, 128);
    logic [CH*W-1:0] exp_cnt = ref_cnt(10, bv);
    launch(200, bv);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.oC !== ref_oc(k, bv)) begin
        errors++;
        $display("FAIL abort_run cycle %0d busy=%b oC=%b expected 1 %b", k, bus.busy, bus.oC, ref_oc(k, bv));
      end
      if (k == 9) bus.abort = 1'b1;
      @(negedge clk);
    end
    bus.abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({bus.busy, bus.done, bus.oC} !== '0 || bus.oCnt !== exp_cnt) begin
        errors++;
        $display("FAIL abort_hold cycle %0d busy=%b done=%b oC=%b oCnt=%h expected idle, oCnt %h",
                 k, bus.busy, bus.done, bus.oC, bus.oCnt, exp_cnt);
      end
      @(negedge clk);
    end
    // abort together with start in IDLE must not capture or clear anything
    bus.iA    = 8'd5;
    bus.iB    = pack4(1, 2, 3, 4);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00 || bus.oCnt !== exp_cnt) begin
      errors++;
      $display("FAIL abort_cancel busy=%b done=%b oCnt=%h expected 0 0 %h",
               bus.busy, bus.done, bus.oCnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    launch(50, pack4(255, 200, 100, 50));
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.oC, bus.oCnt} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run busy=%b done=%b oC=%b oCnt=%h expected all 0",
               bus.busy, bus.done, bus.oC, bus.oCnt);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_run_idle busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
  endtask

  initial begin
    test_reset();
    test_window(255, pack4(128, 0, 255, 64), "full");
    test_window(128, pack4(64, 128, 32, 1), "half");
    test_zero();
    test_back_to_back();
    test_abort();
    test_reset_mid_run();
    for (int n = 0; n < 8; n++) begin
      test_window($urandom_range(1, 80),
                  pack4($urandom_range(0, 255), $urandom_range(0, 255),
                        $urandom_range(0, 255), $urandom_range(0, 255)), "random");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
